// File: rtl/eth_frame_buf_if.sv
// ============================================================================
// Module   : eth_frame_buf_if
// Brief    : Byte-source / transmitter-read bundle for the Ethernet frame buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface eth_frame_buf_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic [10:0] txad;
    logic [7:0]  data1;
    logic        idx;
    logic [15:0] frame_cnt;
    logic        busy;

    modport master (
        output in_valid, in_data, flush, txad,
        input  in_ready, data1, idx, frame_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, flush, txad,
        output in_ready, data1, idx, frame_cnt, busy
    );
endinterface

`default_nettype wire

// File: rtl/eth_frame_buf.sv
// ============================================================================
// Module   : eth_frame_buf
// Brief    : 2 x 1024-byte ping-pong payload buffer; toggles idx to launch a bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_frame_buf #(
    parameter int          MIN_GAP  = 1100,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  wire logic      clk125,
    input  wire logic      rst_n,
    eth_frame_buf_if.slave bus
);

    localparam int                   c_GAP_W    = $clog2(MIN_GAP) + 1;
    localparam logic [c_GAP_W-1:0]   c_GAP_LOAD = c_GAP_W'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    logic [7:0]          r_mem [0:2047];
    state_t              r_state;
    logic                r_wbank;
    logic [9:0]          r_waddr;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_idx;
    logic [15:0]         r_frame_cnt;
    logic [7:0]          r_data1;

    logic                w_accept;
    logic                w_pad_wr;
    logic                w_we;
    logic                w_last;
    logic [7:0]          w_wdata;

    assign w_accept = (r_state == S_FILL) && bus.in_valid;
    assign w_pad_wr = (r_state == S_PAD);
    assign w_we     = w_accept || w_pad_wr;
    assign w_last   = (r_waddr == 10'd1023);
    assign w_wdata  = w_pad_wr ? PAD_BYTE : bus.in_data;

    // Storage is deliberately unreset; only the read register has a reset value.
    always_ff @(posedge clk125) begin
        if (w_we) begin
            r_mem[{r_wbank, r_waddr}] <= w_wdata;
        end
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_data1 <= 8'h00;
        end else begin
            r_data1 <= r_mem[bus.txad];
        end
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_wbank     <= 1'b0;
            r_waddr     <= 10'd0;
            r_gap_cnt   <= '0;
            r_idx       <= 1'b1;
            r_frame_cnt <= 16'd0;
        end else begin
            if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_waddr <= r_waddr + 10'd1;
                        if (w_last) begin
                            r_state <= S_WAIT;
                        end else if (bus.flush) begin
                            r_state <= S_PAD;
                        end
                    end else if (bus.flush && (r_waddr != 10'd0)) begin
                        r_state <= S_PAD;
                    end
                end
                S_PAD: begin
                    r_waddr <= r_waddr + 10'd1;
                    if (w_last) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Launch overrides the decrement above; the new bank starts filling.
                    if (r_gap_cnt == '0) begin
                        r_idx       <= r_wbank;
                        r_wbank     <= ~r_wbank;
                        r_waddr     <= 10'd0;
                        r_gap_cnt   <= c_GAP_LOAD;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (r_state == S_FILL);
    assign bus.busy      = (r_state == S_PAD) || (r_state == S_WAIT);
    assign bus.idx       = r_idx;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.data1     = r_data1;

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_buf.sv
// ============================================================================
// Module   : tb_eth_frame_buf
// Brief    : Randomized self-checking bench for eth_frame_buf with a bank-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eth_frame_buf;

    localparam int         MIN_GAP  = 1100;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    logic clk125 = 1'b0;
    logic rst_n  = 1'b0;

    always #4 clk125 = ~clk125;

    eth_frame_buf_if bus ();

    eth_frame_buf #(
        .MIN_GAP  (MIN_GAP),
        .PAD_BYTE (PAD_BYTE)
    ) dut (
        .clk125 (clk125),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int         checks = 0;
    int         errors = 0;

    // Reference model: fill level of the current bank, timestamps for launches
    int         m_fill;
    bit         m_pad;
    bit         m_full;
    bit         m_wbank;
    bit         m_idx;
    int         m_frames;
    longint     m_cyc = 0;
    longint     m_last;
    logic [7:0] m_mem   [2048];
    bit         m_known [2048];
    bit         m_rd_ok;
    logic [7:0] m_rd;

    logic       trk_idx;
    bit         trk_have;
    longint     tog_last;
    longint     tog_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    function automatic void model_reset();
        m_fill   = 0;
        m_pad    = 0;
        m_full   = 0;
        m_wbank  = 0;
        m_idx    = 1;
        m_frames = 0;
        m_last   = m_cyc - MIN_GAP;
        m_rd_ok  = 1;
        m_rd     = 8'h00;
        for (int i = 0; i < 2048; i++) m_known[i] = 0;
        trk_idx  = 1'b1;
        trk_have = 0;
        tog_last = 0;
        tog_prev = 0;
    endfunction

    function automatic bit model_ready();
        return rst_n && !m_full && !m_pad;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        int a;
        a = (m_wbank ? 1024 : 0) + m_fill;
        m_mem[a]   = d;
        m_known[a] = 1;
        m_fill++;
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] d, input bit f, input logic [10:0] a);
        m_rd_ok = m_known[a];
        m_rd    = m_mem[a];
        if (!m_full && !m_pad) begin
            if (v) begin
                model_write(d);
                if (m_fill == 1024) m_full = 1;
                else if (f)         m_pad  = 1;
            end else if (f && m_fill != 0) begin
                m_pad = 1;
            end
        end else if (m_pad) begin
            model_write(PAD_BYTE);
            if (m_fill == 1024) begin
                m_pad  = 0;
                m_full = 1;
            end
        end else if (m_cyc - m_last >= MIN_GAP) begin
            m_idx    = m_wbank;
            m_wbank  = ~m_wbank;
            m_fill   = 0;
            m_full   = 0;
            m_frames = (m_frames + 1) % 65536;
            m_last   = m_cyc;
        end
    endfunction

    task automatic compare_all();
        chk("idx",       32'(bus.idx),       32'(m_idx));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames));
        chk("in_ready",  32'(bus.in_ready),  32'(model_ready()));
        chk("busy",      32'(bus.busy),      32'(rst_n && (m_pad || m_full)));
        if (m_rd_ok) chk("data1", 32'(bus.data1), 32'(m_rd));
        if (rst_n && bus.idx !== trk_idx) begin
            if (trk_have) chk("toggle_spacing", 32'(m_cyc - tog_last >= MIN_GAP), 32'd1);
            tog_prev = tog_last;
            tog_last = m_cyc;
            trk_have = 1;
            trk_idx  = bus.idx;
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit f, input logic [10:0] a);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        bus.txad     = a;
        @(posedge clk125);
        m_cyc++;
        if (rst_n) model_edge(v, d, f, a);
        else       model_reset();
        #1;
        compare_all();
    endtask

    function automatic logic [10:0] rnd_a();
        return 11'($urandom_range(0, 2047));
    endfunction

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, rnd_a());
        rst_n = 1'b1;
        #1;
        chk("rst_idx",       32'(bus.idx),       32'd1);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
    endtask

    // mode 0: k & 8'hFF, mode 1: random, mode 2: 8'hA0 + k
    task automatic send(input int n, input int mode, input bit flush_last);
        int         sent = 0;
        int         guard = 0;
        bit         rdy;
        logic [7:0] d;
        while (sent < n && guard < 5000) begin
            rdy = model_ready();
            d   = (mode == 0) ? 8'(sent) : (mode == 1) ? 8'($urandom) : 8'(8'hA0 + sent);
            cyc(1, d, flush_last && (sent == n - 1), rnd_a());
            if (rdy) sent++;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("send_count", 32'(sent), 32'(n));
    endtask

    task automatic wait_launch(input string tag, input int limit);
        int f0 = m_frames;
        int i  = 0;
        while (m_frames == f0 && i < limit) begin
            cyc(0, 8'h00, 0, rnd_a());
            i++;
        end
        chk(tag, 32'(bus.frame_cnt), 32'((f0 + 1) % 65536));
    endtask

    task automatic readback(input string tag, input logic [10:0] a, input logic [7:0] exp);
        cyc(0, 8'h00, 0, a);
        chk(tag, 32'(bus.data1), 32'(exp));
    endtask

    initial begin
        longint t;
        logic [10:0] a;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.flush    = 1'b0;
        bus.txad     = 11'd0;

        do_reset(10);

        // Single frame with counting pattern
        send(1024, 0, 0);
        t = m_cyc;
        chk("sf_idx_hold", 32'(bus.idx), 32'd1);
        cyc(0, 8'h00, 0, rnd_a());
        chk("sf_launch_delay", 32'(tog_last - t), 32'd1);
        chk("sf_idx", 32'(bus.idx), 32'd0);
        chk("sf_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        readback("sf_rd0",    11'd0,    8'h00);
        readback("sf_rd1",    11'd1,    8'h01);
        readback("sf_rd511",  11'd511,  8'hFF);
        readback("sf_rd1023", 11'd1023, 8'hFF);

        // Back-to-back: second bank is held off by the toggle spacing
        do_reset(10);
        send(2048, 0, 0);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd0);
        chk("b2b_busy",     32'(bus.busy),     32'd1);
        wait_launch("b2b_launch", 2000);
        chk("b2b_gap",   32'(tog_last - tog_prev), 32'(MIN_GAP));
        chk("b2b_idx",   32'(bus.idx),       32'd1);
        chk("b2b_count", 32'(bus.frame_cnt), 32'd2);

        // Partial bank flushed with padding
        do_reset(10);
        send(10, 2, 0);
        cyc(0, 8'h00, 1, rnd_a());
        t = m_cyc;
        chk("fl_busy", 32'(bus.busy), 32'd1);
        wait_launch("fl_launch", 1200);
        chk("fl_launch_delay", 32'(tog_last - t), 32'd1015);
        for (int k = 0; k < 10; k++) begin
            a = 11'(k);
            readback("fl_data", a, 8'(8'hA0 + k));
        end
        readback("fl_pad10",   11'd10,   PAD_BYTE);
        readback("fl_pad500",  11'd500,  PAD_BYTE);
        readback("fl_pad1023", 11'd1023, PAD_BYTE);

        // Flush on an empty bank does nothing
        do_reset(10);
        cyc(0, 8'h00, 1, rnd_a());
        chk("fl0_busy",     32'(bus.busy),     32'd0);
        chk("fl0_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 1200; i++) cyc(0, 8'h00, 0, rnd_a());
        chk("fl0_frames", 32'(bus.frame_cnt), 32'd0);

        // Flush together with the final byte: straight to launch, no padding
        do_reset(10);
        send(1024, 1, 1);
        t = m_cyc;
        cyc(0, 8'h00, 0, rnd_a());
        chk("flc_launch_delay", 32'(tog_last - t), 32'd1);
        chk("flc_frames",       32'(bus.frame_cnt), 32'd1);

        // Reset pulse mid-fill discards the partial bank
        do_reset(10);
        send(500, 1, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_idx",      32'(bus.idx),       32'd1);
        chk("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
        chk("mid_rst_frames",   32'(bus.frame_cnt), 32'd0);
        cyc(0, 8'h00, 0, rnd_a());
        rst_n = 1'b1;
        #1;
        send(1023, 1, 0);
        chk("mid_no_launch", 32'(bus.idx), 32'd1);
        send(1, 1, 0);
        wait_launch("mid_launch", 4);
        chk("mid_idx", 32'(bus.idx), 32'd0);

        // Random traffic with sporadic flushes
        do_reset(10);
        for (int i = 0; i < 20000; i++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 199) == 0), rnd_a());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
